// File: rtl/shift_reg_r_ce_pkg.sv
// Shared definitions for the shift_reg_r_ce multi-stage register.
// Holds the operating-mode encoding used by the top and by each stage.
package shift_reg_r_ce_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_ROT   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_reg_r_ce_stage.sv
// One WIDTH-bit stage of shift_reg_r_ce.
// It has a synchronous reset, a clear, an enable and a 4:1 next-value select.
module shift_stage
    import shift_reg_r_ce_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             ce,
    input  mode_e            sel,
    input  logic [WIDTH-1:0] shift_src,
    input  logic [WIDTH-1:0] rot_src,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;

    // Select the candidate next value from the operating mode.
    always_comb begin
        next_s = q_r;
        case (sel)
            MODE_HOLD:  next_s = q_r;
            MODE_SHIFT: next_s = shift_src;
            MODE_ROT:   next_s = rot_src;
            MODE_LOAD:  next_s = load_val;
            default:    next_s = q_r;
        endcase
    end

    // Stage register: reset beats clear, and clear beats the enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_r <= RESET_VAL;
        end else if (clr) begin
            q_r <= RESET_VAL;
        end else if (ce) begin
            q_r <= next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/shift_reg_r_ce.sv
// DEPTH-stage register with hold, shift, rotate and parallel-load modes.
// It also tracks how many stages hold valid data in a saturating counter.
module shift_reg_r_ce
    import shift_reg_r_ce_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce,
    input  logic                         clr,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             d_in,
    input  logic [DEPTH*WIDTH-1:0]       pload,
    output logic [WIDTH-1:0]             q_out,
    output logic [DEPTH*WIDTH-1:0]       q_all,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         full
);

    localparam int            FW      = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);
    localparam logic [FW-1:0] ONE_C   = FW'(1);
    localparam logic [FW-1:0] ZERO_C  = FW'(0);

    mode_e            mode_s;
    logic [WIDTH-1:0] stage_q_s [DEPTH];
    logic [FW-1:0]    fill_r;
    logic [FW-1:0]    fill_next_s;

    assign mode_s = mode_e'(mode);

    // Stage 0 takes d_in on shift and the oldest stage on rotate; later stages follow their predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] shift_src_s;
        logic [WIDTH-1:0] rot_src_s;

        if (k == 0) begin : g_head
            assign shift_src_s = d_in;
            assign rot_src_s   = stage_q_s[DEPTH-1];
        end else begin : g_body
            assign shift_src_s = stage_q_s[k-1];
            assign rot_src_s   = stage_q_s[k-1];
        end

        shift_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr       (clr),
            .ce        (ce),
            .sel       (mode_s),
            .shift_src (shift_src_s),
            .rot_src   (rot_src_s),
            .load_val  (pload[k*WIDTH +: WIDTH]),
            .q         (stage_q_s[k])
        );

        assign q_all[k*WIDTH +: WIDTH] = stage_q_s[k];
    end

    assign q_out = stage_q_s[DEPTH-1];

    // Next fill count: shift saturates at DEPTH, load fills every stage.
    always_comb begin
        fill_next_s = fill_r;
        case (mode_s)
            MODE_HOLD: fill_next_s = fill_r;
            MODE_SHIFT: begin
                if (fill_r == DEPTH_C) begin
                    fill_next_s = DEPTH_C;
                end else begin
                    fill_next_s = fill_r + ONE_C;
                end
            end
            MODE_ROT:  fill_next_s = fill_r;
            MODE_LOAD: fill_next_s = DEPTH_C;
            default:   fill_next_s = fill_r;
        endcase
    end

    // Fill counter with the same reset/clear/enable priority as the stages.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill_r <= ZERO_C;
        end else if (clr) begin
            fill_r <= ZERO_C;
        end else if (ce) begin
            fill_r <= fill_next_s;
        end else begin
            fill_r <= fill_r;
        end
    end

    assign fill = fill_r;
    assign full = (fill_r == DEPTH_C);

endmodule

// File: tb/tb_shift_reg_r_ce.sv
// Self-checking bench for shift_reg_r_ce: directed scenarios plus random traffic
// against a queue-based reference model, on a default instance and a DEPTH=1 instance.
module tb_shift_reg_r_ce;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce, clr;
    logic [1:0]  mode;
    logic [7:0]  d_in;
    logic [31:0] pload;
    logic [7:0]  q_out;
    logic [31:0] q_all;
    logic [2:0]  fill;
    logic        full;

    logic        c_ce, c_clr;
    logic [1:0]  c_mode;
    logic [0:0]  c_d_in, c_pload, c_q_out, c_q_all, c_fill;
    logic        c_full;

    int checks = 0;
    int errors = 0;

    // Reference model: stage k is mq[k]; the oldest stage is the last entry.
    logic [7:0] mq[$];
    int         m_fill;
    logic       c_m;
    int         c_mfill;

    always #5 clk = ~clk;

    shift_reg_r_ce #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .clr(clr), .mode(mode),
        .d_in(d_in), .pload(pload), .q_out(q_out), .q_all(q_all),
        .fill(fill), .full(full)
    );

    shift_reg_r_ce #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut_c (
        .clk(clk), .reset_n(reset_n), .ce(c_ce), .clr(c_clr), .mode(c_mode),
        .d_in(c_d_in), .pload(c_pload), .q_out(c_q_out), .q_all(c_q_all),
        .fill(c_fill), .full(c_full)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] t;
        if (!reset_n || clr) begin
            mq = '{8'h00, 8'h00, 8'h00, 8'h00};
            m_fill = 0;
        end else if (ce) begin
            case (mode)
                2'b01: begin
                    void'(mq.pop_back());
                    mq.push_front(d_in);
                    m_fill = (m_fill < 4) ? m_fill + 1 : 4;
                end
                2'b10: begin
                    t = mq.pop_back();
                    mq.push_front(t);
                end
                2'b11: begin
                    for (int k = 0; k < 4; k++) mq[k] = pload[k*8 +: 8];
                    m_fill = 4;
                end
                default: ;
            endcase
        end
        if (!reset_n || c_clr) begin
            c_m = 1'b1;
            c_mfill = 0;
        end else if (c_ce) begin
            case (c_mode)
                2'b01: begin c_m = c_d_in[0]; c_mfill = 1; end
                2'b11: begin c_m = c_pload[0]; c_mfill = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_all;
        for (int k = 0; k < 4; k++) exp_all[k*8 +: 8] = mq[k];
        check_eq("q_all", {32'h0, q_all}, {32'h0, exp_all});
        check_eq("q_out", {56'h0, q_out}, {56'h0, mq[3]});
        check_eq("fill", {61'h0, fill}, 64'(m_fill));
        check_eq("full", {63'h0, full}, {63'h0, (m_fill == 4)});
        check_eq("c_q_out", {63'h0, c_q_out}, {63'h0, c_m});
        check_eq("c_q_all", {63'h0, c_q_all}, {63'h0, c_m});
        check_eq("c_fill", {63'h0, c_fill}, 64'(c_mfill));
        check_eq("c_full", {63'h0, c_full}, {63'h0, (c_mfill == 1)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic shift_in(input logic [7:0] v);
        mode = 2'b01;
        d_in = v;
        tick();
    endtask

    logic [7:0] rot_exp [4];

    initial begin
        mq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
        m_fill = 3;
        c_m = 1'b0;
        c_mfill = 0;
        reset_n = 1'b0; ce = 1'b1; clr = 1'b0; mode = 2'b01; d_in = 8'hFF; pload = 32'h0;
        c_ce = 1'b1; c_clr = 1'b0; c_mode = 2'b01; c_d_in = 1'b0; c_pload = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_q_all", {32'h0, q_all}, 64'h0);
        check_eq("rst_c_q_out", {63'h0, c_q_out}, 64'h1);

        // Fill the register; corner instance shifts in 0 and then rotates.
        reset_n = 1'b1;
        shift_in(8'h11);
        check_eq("c_shift_q", {63'h0, c_q_out}, 64'h0);
        check_eq("c_shift_full", {63'h0, c_full}, 64'h1);
        c_mode = 2'b10;
        shift_in(8'h22);
        shift_in(8'h33);
        shift_in(8'h44);
        check_eq("fill4_q_out", {56'h0, q_out}, 64'h11);
        check_eq("fill4_full", {63'h0, full}, 64'h1);
        check_eq("c_rot_q", {63'h0, c_q_out}, 64'h0);
        shift_in(8'h55);
        check_eq("sat_q_out", {56'h0, q_out}, 64'h22);
        check_eq("sat_fill", {61'h0, fill}, 64'h4);

        // A reset pulse that does not span a rising edge has no effect.
        mode = 2'b00;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        check_eq("glitch_fill", {61'h0, fill}, 64'h4);

        mode = 2'b11;
        pload = 32'hD4C3B2A1;
        tick();
        check_eq("load_q_all", {32'h0, q_all}, 64'hD4C3B2A1);
        rot_exp = '{8'hC3, 8'hB2, 8'hA1, 8'hD4};
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rot_q_out", {56'h0, q_out}, {56'h0, rot_exp[i]});
        end
        check_eq("rot_back", {32'h0, q_all}, 64'hD4C3B2A1);

        ce = 1'b0;
        mode = 2'b01;
        d_in = 8'hEE;
        for (int i = 0; i < 3; i++) tick();
        check_eq("ce0_hold", {32'h0, q_all}, 64'hD4C3B2A1);
        clr = 1'b1;
        tick();
        check_eq("clr_ce0_fill", {61'h0, fill}, 64'h0);
        clr = 1'b0; ce = 1'b1; mode = 2'b11;
        tick();
        clr = 1'b1;
        tick();
        check_eq("clr_over_load", {32'h0, q_all}, 64'h0);
        clr = 1'b0;

        shift_in(8'h12);
        shift_in(8'h34);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        shift_in(8'h7E);
        check_eq("rst_mid_s0", {56'h0, q_all[7:0]}, 64'h7E);
        check_eq("rst_mid_fill", {61'h0, fill}, 64'h1);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 39) != 0);
            clr     = ($urandom_range(0, 19) == 0);
            ce      = ($urandom_range(0, 4) != 0);
            mode    = 2'($urandom_range(0, 3));
            d_in    = 8'($urandom);
            pload   = $urandom;
            c_clr   = ($urandom_range(0, 19) == 0);
            c_ce    = ($urandom_range(0, 4) != 0);
            c_mode  = 2'($urandom_range(0, 3));
            c_d_in  = 1'($urandom);
            c_pload = 1'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
